// File: rtl/sync_pkg.sv
// Shared Gray/binary conversion and sizing helpers for the synchronizer slice.
// Conversions work on a 64-bit word; zero-extended narrower values convert correctly.
package sync_pkg;

   localparam int unsigned SYNC_MAXW = 64;
   typedef logic [SYNC_MAXW-1:0] sync_word_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic sync_word_t bin2gray(input sync_word_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic sync_word_t gray2bin(input sync_word_t g);
      sync_word_t b;
      b[SYNC_MAXW-1] = g[SYNC_MAXW-1];
      for (int unsigned i = SYNC_MAXW-1; i > 0; i--) b[i-1] = b[i] ^ g[i-1];
      return b;
   endfunction

endpackage

// File: rtl/FFchain.sv
// DEPTH-stage flip-flop synchronizer chain with async active-high reset.
module FFchain #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ena_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (ena_i) begin
         r_stage[0] <= d_i;
         for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign q_o = r_stage[DEPTH-1];

endmodule

// File: rtl/gray_sync_mc.sv
// Multi-channel Gray-code synchronizer: registered binary outputs, fill-based valid,
// per-channel change strobes and sticky step-violation flags.
module gray_sync_mc
   import sync_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned CHANNELS = 1,
   parameter bit          IN_GRAY  = 1'b0,
   parameter int unsigned MAXSTEP  = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [CHANNELS*WIDTH-1:0] data_i,
   input  logic                      clr_i,
   output logic [CHANNELS*WIDTH-1:0] data_o,
   output logic                      valid_o,
   output logic [CHANNELS-1:0]       chg_o,
   output logic [CHANNELS-1:0]       err_o
);

   localparam int unsigned TOTAL_W = CHANNELS * WIDTH;
   localparam int unsigned FILL_W  = clog2(DEPTH + 2);

   logic [TOTAL_W-1:0] w_gray;
   logic [TOTAL_W-1:0] w_sync;
   logic [FILL_W-1:0]  r_fill;
   logic               r_valid;

   FFchain #(
      .WIDTH(TOTAL_W),
      .DEPTH(DEPTH)
   ) u_chain (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .ena_i(1'b1),
      .d_i  (w_gray),
      .q_o  (w_sync)
   );

   // Valid rises on the edge that loads the first fully synchronized sample.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fill  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (r_fill != FILL_W'(DEPTH + 1)) r_fill <= r_fill + FILL_W'(1);
         r_valid <= (r_fill >= FILL_W'(DEPTH)) || r_valid;
      end
   end

   assign valid_o = r_valid;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic [WIDTH-1:0] w_cur;
      logic [WIDTH-1:0] w_fwd;
      logic [WIDTH-1:0] w_back;
      logic             w_viol;
      logic [WIDTH-1:0] r_data;
      logic             r_chg;
      logic             r_err;

      if (IN_GRAY) begin : g_gin
         assign w_gray[n*WIDTH +: WIDTH] = data_i[n*WIDTH +: WIDTH];
      end else begin : g_bin
         assign w_gray[n*WIDTH +: WIDTH] = WIDTH'(bin2gray(SYNC_MAXW'(data_i[n*WIDTH +: WIDTH])));
      end

      // Modular distance both ways; min(fwd, back) > MAXSTEP <=> both exceed it.
      always_comb begin
         w_cur  = WIDTH'(gray2bin(SYNC_MAXW'(w_sync[n*WIDTH +: WIDTH])));
         w_fwd  = w_cur - r_data;
         w_back = r_data - w_cur;
         w_viol = (SYNC_MAXW'(w_fwd) > SYNC_MAXW'(MAXSTEP)) &&
                  (SYNC_MAXW'(w_back) > SYNC_MAXW'(MAXSTEP));
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_data <= '0;
            r_chg  <= 1'b0;
            r_err  <= 1'b0;
         end else begin
            r_data <= w_cur;
            r_chg  <= r_valid && (w_cur != r_data);
            if (r_valid && w_viol) r_err <= 1'b1;
            else if (clr_i)        r_err <= 1'b0;
         end
      end

      assign data_o[n*WIDTH +: WIDTH] = r_data;
      assign chg_o[n]                 = r_chg;
      assign err_o[n]                 = r_err;
   end

endmodule
